// File: rtl/trap_ctrl.sv
// Commit-stage trap sequencer: retire/trap/mret pulses, privilege level, flush and fetch redirect.
// Optional timer-interrupt entry is compiled in with `define TRAP_IRQ_EN.
module trap_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_stall,
    input  logic                  commit_valid,
    input  logic [DATA_WIDTH-1:0] commit_pc,
    input  logic                  commit_exc,
    input  logic [DATA_WIDTH-1:0] commit_cause,
    input  logic [DATA_WIDTH-1:0] commit_tval,
    input  logic                  commit_mret,
    input  logic [DATA_WIDTH-1:0] handler_addr,
    input  logic [DATA_WIDTH-1:0] mret_out,
    input  logic [DATA_WIDTH-1:0] mstatus_out,
    input  logic                  irq_timer,
    output logic [1:0]            priv_level,
    output logic                  inst_commit,
    output logic                  exception_commit,
    output logic                  mret_commit,
    output logic [DATA_WIDTH-1:0] exception_pc,
    output logic [DATA_WIDTH-1:0] exception_cause,
    output logic [DATA_WIDTH-1:0] exception_tval,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DATA_WIDTH-1:0] IRQ_CAUSE = {1'b1, {(DATA_WIDTH-4){1'b0}}, 3'd7};

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [DATA_WIDTH-1:0]   rpc_q, rpc_nx;
    logic [1:0]              priv_q, priv_nx;
    logic                    accept, take_exc, take_irq, take_mret;
    logic [DATA_WIDTH-1:0]   tvec_base, irq_vec;
    logic                    unused_bits;

    assign accept    = commit_valid & ~mem_stall & (state == IDLE);
    assign take_exc  = accept & commit_exc;
    assign take_mret = accept & commit_mret & ~commit_exc;
    assign tvec_base = {handler_addr[DATA_WIDTH-1:2], 2'b00};

`ifdef TRAP_IRQ_EN
    assign take_irq = accept & irq_timer & mstatus_out[3] & ~commit_exc & ~commit_mret;
    // Vectored mode (mode==1) jumps to base + 4*cause for the timer interrupt.
    assign irq_vec  = (handler_addr[1:0] == 2'b01) ? tvec_base + DATA_WIDTH'(28) : tvec_base;
`else
    assign take_irq = 1'b0;
    assign irq_vec  = tvec_base;
`endif

    assign unused_bits = ^{mstatus_out, irq_timer, irq_vec};

    assign priv_level  = priv_q;
    assign redirect_pc = rpc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rpc_q  <= '0;
            priv_q <= 2'b11;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            rpc_q  <= rpc_nx;
            priv_q <= priv_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        rpc_nx           = rpc_q;
        priv_nx          = priv_q;
        inst_commit      = 1'b0;
        exception_commit = 1'b0;
        mret_commit      = 1'b0;
        exception_pc     = '0;
        exception_cause  = '0;
        exception_tval   = '0;
        flush            = 1'b0;
        redirect_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (take_exc || take_irq) begin
                    exception_commit = 1'b1;
                    exception_pc     = commit_pc;
                    exception_cause  = take_exc ? commit_cause : IRQ_CAUSE;
                    exception_tval   = take_exc ? commit_tval : '0;
                    flush            = 1'b1;
                    rpc_nx           = take_exc ? tvec_base : irq_vec;
                    priv_nx          = 2'b11;
                    cnt_nx           = CW'(FLUSH_CYCLES - 1);
                    state_nx         = FLUSH;
                end else if (take_mret) begin
                    mret_commit = 1'b1;
                    inst_commit = 1'b1;
                    flush       = 1'b1;
                    rpc_nx      = mret_out;
                    priv_nx     = mstatus_out[12:11];
                    cnt_nx      = CW'(FLUSH_CYCLES - 1);
                    state_nx    = FLUSH;
                end else if (accept) begin
                    inst_commit = 1'b1;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt == '0) state_nx = REDIRECT;
                else           cnt_nx   = cnt - CW'(1);
            end
            REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed literal checks plus randomized traffic against a cycle-level model.
module tb_trap_ctrl;
    localparam int DW = 32;
    localparam int F  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_stall = 1'b0, commit_valid = 1'b0, commit_exc = 1'b0, commit_mret = 1'b0;
    logic          irq_timer = 1'b0;
    logic [DW-1:0] commit_pc = '0, commit_cause = '0, commit_tval = '0;
    logic [DW-1:0] handler_addr = '0, mret_out = '0, mstatus_out = '0;
    logic [1:0]    priv_level;
    logic          inst_commit, exception_commit, mret_commit, flush, redirect_valid;
    logic [DW-1:0] exception_pc, exception_cause, exception_tval, redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    trap_ctrl #(.DATA_WIDTH(DW), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_exc(commit_exc), .commit_cause(commit_cause),
        .commit_tval(commit_tval), .commit_mret(commit_mret), .handler_addr(handler_addr),
        .mret_out(mret_out), .mstatus_out(mstatus_out), .irq_timer(irq_timer),
        .priv_level(priv_level), .inst_commit(inst_commit), .exception_commit(exception_commit),
        .mret_commit(mret_commit), .exception_pc(exception_pc), .exception_cause(exception_cause),
        .exception_tval(exception_tval), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; everything is sampled on the falling edge.
    task automatic set_in(input logic v, input logic stall, input logic [DW-1:0] pc,
                          input logic exc, input logic [DW-1:0] cause, input logic [DW-1:0] tval,
                          input logic mret, input logic [DW-1:0] haddr, input logic [DW-1:0] mepc,
                          input logic [DW-1:0] mst, input logic irq);
        @(posedge clk);
        #1;
        commit_valid = v; mem_stall = stall; commit_pc = pc; commit_exc = exc;
        commit_cause = cause; commit_tval = tval; commit_mret = mret; handler_addr = haddr;
        mret_out = mepc; mstatus_out = mst; irq_timer = irq;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) set_in(0, 0, 0, 0, 0, 0, 0, handler_addr, mret_out, mstatus_out, 0);
    endtask

    // Reference model: a pending redirect is described by "cycles left until redirect".
    logic          m_busy = 1'b0;
    int            m_left = 0;
    logic [DW-1:0] m_rpc  = '0;
    logic [1:0]    m_priv = 2'b11;

    always @(negedge clk) begin
        logic          e_inst, e_exc, e_mret, e_flush, e_rv, start;
        logic [DW-1:0] e_epc, e_cause, e_tval, n_rpc, base;
        logic [1:0]    n_priv;
        if (rst) begin
            m_busy = 1'b0; m_rpc = '0; m_priv = 2'b11;
            chk("rst_flush", flush, 0);
            chk("rst_redirect_valid", redirect_valid, 0);
            chk("rst_pulses", {inst_commit, exception_commit, mret_commit}, 0);
            chk("rst_priv", priv_level, 3);
            chk("rst_redirect_pc", redirect_pc, 0);
        end else begin
            e_inst = 0; e_exc = 0; e_mret = 0; e_flush = 0; e_rv = 0; start = 0;
            e_epc = 0; e_cause = 0; e_tval = 0; n_rpc = m_rpc; n_priv = m_priv;
            base = handler_addr & ~32'd3;
            if (m_busy) begin
                e_flush = 1;
                e_rv    = (m_left == 0);
            end else if (commit_valid && !mem_stall) begin
                if (commit_exc) begin
                    e_exc = 1; e_epc = commit_pc; e_cause = commit_cause; e_tval = commit_tval;
                    n_rpc = base; n_priv = 3; start = 1;
`ifdef TRAP_IRQ_EN
                end else if (irq_timer && mstatus_out[3] && !commit_mret) begin
                    e_exc = 1; e_epc = commit_pc; e_cause = 32'h8000_0007;
                    n_rpc = (handler_addr[1:0] == 2'b01) ? base + 28 : base;
                    n_priv = 3; start = 1;
`endif
                end else if (commit_mret) begin
                    e_mret = 1; e_inst = 1; n_rpc = mret_out; n_priv = mstatus_out[12:11]; start = 1;
                end else begin
                    e_inst = 1;
                end
                e_flush = start;
            end
            chk("inst_commit", inst_commit, e_inst);
            chk("exception_commit", exception_commit, e_exc);
            chk("mret_commit", mret_commit, e_mret);
            chk("flush", flush, e_flush);
            chk("redirect_valid", redirect_valid, e_rv);
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("priv_level", priv_level, m_priv);
            if (e_exc) begin
                chk("exception_pc", exception_pc, e_epc);
                chk("exception_cause", exception_cause, e_cause);
                chk("exception_tval", exception_tval, e_tval);
            end
            if (m_busy) begin
                if (m_left == 0) m_busy = 0;
                else m_left--;
            end else if (start) begin
                m_busy = 1; m_left = F; m_rpc = n_rpc; m_priv = n_priv;
            end
        end
    end

    initial begin
        int pulses;
        // Reset values
        @(negedge clk);
        chk("lit_rst_priv", priv_level, 3);
        chk("lit_rst_flush", flush, 0);
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(2);

        // Synchronous exception: redirect three cycles after the trap cycle
        set_in(1, 0, 32'h100, 1, 2, 32'hDEAD, 0, 32'h800, 0, 0, 0);
        @(negedge clk);
        chk("lit_exc_commit", exception_commit, 1);
        chk("lit_exc_inst", inst_commit, 0);
        chk("lit_exc_pc", exception_pc, 32'h100);
        chk("lit_exc_tval", exception_tval, 32'hDEAD);
        idle_cycles(2);
        @(negedge clk);
        chk("lit_exc_flush2", flush, 1);
        chk("lit_exc_rv_early", redirect_valid, 0);
        idle_cycles(1);
        @(negedge clk);
        chk("lit_exc_rv", redirect_valid, 1);
        chk("lit_exc_rpc", redirect_pc, 32'h800);
        chk("lit_exc_priv", priv_level, 3);
        idle_cycles(1);
        @(negedge clk);
        chk("lit_exc_flush_done", flush, 0);

        // MRET to MPP=0; an exception arriving during FLUSH is ignored
        set_in(1, 0, 32'h50, 0, 0, 0, 1, 32'h800, 32'h104, 0, 0);
        @(negedge clk);
        chk("lit_mret_commit", mret_commit, 1);
        chk("lit_mret_inst", inst_commit, 1);
        set_in(1, 0, 32'h60, 1, 5, 0, 0, 32'h900, 32'h200, 0, 0);
        @(negedge clk);
        chk("lit_flush_exc_ignored", exception_commit, 0);
        chk("lit_mret_priv", priv_level, 0);
        idle_cycles(2);
        @(negedge clk);
        chk("lit_mret_rv", redirect_valid, 1);
        chk("lit_mret_rpc", redirect_pc, 32'h104);
        idle_cycles(1);

        // Exception and MRET together: exception wins
        set_in(1, 0, 32'h70, 1, 3, 0, 1, 32'h400, 32'h300, 32'h1800, 0);
        @(negedge clk);
        chk("lit_both_exc", exception_commit, 1);
        chk("lit_both_mret", mret_commit, 0);
        idle_cycles(4);

        // Stalled exception stays pending until the stall drops
        set_in(1, 1, 32'h80, 1, 4, 0, 0, 32'h400, 0, 0, 0);
        @(negedge clk);
        chk("lit_stall_exc", exception_commit, 0);
        chk("lit_stall_flush", flush, 0);
        set_in(1, 0, 32'h80, 1, 4, 0, 0, 32'h400, 0, 0, 0);
        @(negedge clk);
        chk("lit_unstall_exc", exception_commit, 1);
        idle_cycles(4);

        // Ten plain retirements
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(1, 0, 32'h1000 + 4 * i, 0, 0, 0, 0, 32'h400, 0, 0, 0);
            @(negedge clk);
            if (inst_commit) pulses++;
            chk("lit_plain_flush", flush, 0);
        end
        chk("lit_plain_count", pulses, 10);
        idle_cycles(1);

`ifdef TRAP_IRQ_EN
        set_in(1, 0, 32'h200, 0, 0, 0, 0, 32'h801, 0, 32'h8, 1);
        @(negedge clk);
        chk("lit_irq_exc", exception_commit, 1);
        chk("lit_irq_cause", exception_cause, 32'h8000_0007);
        chk("lit_irq_inst", inst_commit, 0);
        idle_cycles(3);
        @(negedge clk);
        chk("lit_irq_rpc", redirect_pc, 32'h81C);
        idle_cycles(1);
`endif

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                @(posedge clk);
                #2;
                commit_valid = 0; commit_exc = 0; commit_mret = 0; irq_timer = 0; mem_stall = 0;
                rst = 1'b1;
                @(posedge clk);
                #2;
                rst = 1'b0;
            end else begin
                set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20, $urandom,
                       $urandom_range(0, 99) < 15, $urandom_range(0, 15), $urandom,
                       $urandom_range(0, 99) < 15, $urandom, $urandom, $urandom,
                       $urandom_range(0, 99) < 30);
            end
        end
        idle_cycles(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
